cmd_exec_sched: RTL and testbench
=================================

# cmd_exec_sched

Execution scheduler for the real-time command memory writer. Pulls the next prepared command from the writer via `REQ_COMM`/`DATA_WR` and holds it until system time reaches `TIME_START`. It then plays the impulse train: `N_impulse` pulses, each `Interval_Ti` cycles high and `Interval_Tp` cycles low, with blanking windows around each pulse. When the train finishes it requests the next command, so it closes the loop between the command store and the synchronization/execution chain.

## Interface

Parameters:
- `TIMEOUT` — default 4096 — cycles to wait for `DATA_WR` after `REQ_COMM`. Used only with `SCHED_TIMEOUT_EN`.
- `LATE_MARGIN` — default 0 — cycles of tolerated lateness. A command with `TIME_START + LATE_MARGIN < TIME` at latch time is late.

Ports:
- `CLK` — in — 1 — system clock, 48 MHz domain. Single clock.
- `rst_n` — in — 1 — reset, synchronous, active-low.
- `TIME` — in — 64 — current system time, in `CLK` ticks.
- `SYS_TIME_UPDATE` — in — 1 — system time was reloaded. Level; rising edge used.
- `DATA_WR` — in — 1 — command fields below are valid. One-cycle strobe.
- `TIME_START_z` — in — 64 — command start time.
- `N_impuls_z` — in — 16 — number of pulses.
- `Interval_Ti_z` — in — 32 — pulse high length, in cycles.
- `Interval_Tp_z` — in — 32 — pause length, in cycles.
- `Tblank1_z` — in — 32 — blank lead before each pulse, in cycles.
- `Tblank2_z` — in — 32 — blank tail after each pulse, in cycles.
- `REQ_COMM` — out — 1 — request next command. One-cycle pulse.
- `IMP` — out — 1 — impulse output.
- `BLANK` — out — 1 — receiver blanking gate.
- `BUSY` — out — 1 — high in ARMED, PULSE or PAUSE.
- `CMD_START` — out — 1 — one-cycle strobe on the first `IMP` rise of a command.
- `LATE` — out — 1 — sticky; set when a late command is dropped. Cleared by reset only.
- `TOUT` — out — 1 — sticky; set on `DATA_WR` timeout. Cleared by reset only.

## Operation

States: IDLE, REQ, WAIT, ARMED, PULSE, PAUSE.

- **IDLE:** after reset, go to REQ on the next cycle.
- **REQ:** drive `REQ_COMM`=1 for exactly one cycle, then go to WAIT.
- **WAIT:** on `DATA_WR`, latch all field inputs.
  - If the command is late: set `LATE`, go to REQ.
  - If `N_impuls_z`=0: go to REQ (empty command, no flag).
  - Otherwise go to ARMED.
  - `DATA_WR` in any state other than WAIT is ignored.
- **ARMED:**
  - `BLANK`=1 when `TIME + Tblank1 >= TIME_START`.
  - When `TIME >= TIME_START`, go to PULSE, load the high counter with `max(Ti,1)` and load the pulse counter with N.
- **PULSE:**
  - `IMP`=1 and `BLANK`=1.
  - When the high counter reaches 1: decrement the pulse counter, load the low counter with `Tp`, go to PAUSE.
- **PAUSE:** `IMP`=0.
  - `BLANK`=1 for the first `Tblank2` cycles and the last `Tblank1` cycles of the pause. `BLANK` stays 1 for the whole pause if the two windows overlap.
  - When the low counter expires (Tp=0 means zero-length pause, i.e. immediate):
    - If pulses remain, go to PULSE with the high counter reloaded.
    - Otherwise go to REQ.
  - The final pause is played in full before REQ.
- **SYS_TIME_UPDATE** (rising edge, detected with a 3-bit shift register): in ARMED, PULSE or PAUSE, abort. Force `IMP`=0 and `BLANK`=0, go to REQ. In IDLE, REQ or WAIT it is ignored.
- **Arithmetic:**
  - Time comparisons are 64-bit unsigned.
  - `TIME + Tblank1` is computed in 65 bits; saturation is not needed.
  - Counters are 32-bit, down-counting.
  - The pulse counter is 16-bit.

## Timing

- **Reset values:** `REQ_COMM`, `IMP`, `BLANK`, `BUSY`, `CMD_START`, `LATE`, `TOUT` are all 0. State is IDLE and all counters are 0.
- All outputs are registered.
- **REQ_COMM:** first assertion on cycle 2 after `rst_n` rises.
- **Latch:** `DATA_WR` in cycle k changes state in cycle k+1.
- **Start:** `TIME >= TIME_START` sampled in cycle k drives `IMP`=1 and `CMD_START`=1 in cycle k+1.
- **Pulse shape:** `IMP` is high for exactly `max(Ti,1)` cycles and low for exactly `Tp` cycles between pulses.
- **Next request:** `REQ_COMM` is asserted 1 cycle after the final pause ends.
- **Abort:**
  - Edge at `SYS_TIME_UPDATE` cycle k is detected in cycle k+2.
  - `IMP`=0 and `BLANK`=0 in cycle k+3.
  - `REQ_COMM` is asserted in cycle k+3.

## Configuration

- **`SCHED_TIMEOUT_EN` defined:** WAIT counts cycles. If `TIMEOUT` cycles pass with no `DATA_WR`, set `TOUT` and return to REQ, which re-issues `REQ_COMM`.
- **Undefined:** WAIT blocks indefinitely, `TOUT` is tied to 0, and the counter is not built.

## Test plan

- **Basic train:** reset, then `DATA_WR` with TIME_START=1000, N=3, Ti=10, Tp=20, Tblank1=Tblank2=2. Required:
  - `IMP` high 10 cycles starting the cycle after TIME=1000, three times, 30 cycles apart.
  - `BLANK` rises at TIME=998 and covers each pulse ±2 cycles.
  - `REQ_COMM` is asserted 21 cycles after the third `IMP` fall.
- **Late command:** `DATA_WR` with TIME_START=50 while TIME=100. Required: `LATE`=1, no `IMP`, `REQ_COMM` pulses again 1 cycle later.
- **Degenerate fields:** N=0 → immediate re-request, no `IMP`. Ti=0, Tp=0, N=2 → `IMP` high for 2 consecutive cycles.
- **Abort:** `SYS_TIME_UPDATE` rises mid-PULSE of a N=5 train. Required: `IMP`=0 and `REQ_COMM`=1 exactly 3 cycles later, and no further pulses.
- **Stray strobe:** `DATA_WR` during PULSE with different fields. Required: ignored, current train completes unchanged.
- **Timeout (`SCHED_TIMEOUT_EN`, `TIMEOUT`=16):** no `DATA_WR` after `REQ_COMM`. Required: `TOUT`=1 and `REQ_COMM` re-pulsed 17 cycles after the first one. Without the macro, no re-pulse after 10000 cycles.

Source files
------------

// File: rtl/cmd_exec_sched.sv
// Fetches a command, holds it until TIME_START, then plays N pulses with blanking.
// Define SCHED_TIMEOUT_EN to build the DATA_WR watchdog (TOUT); otherwise WAIT blocks forever.
module cmd_exec_sched #(
  parameter int unsigned TIMEOUT     = 4096,
  parameter int unsigned LATE_MARGIN = 0
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic [63:0] TIME,
  input  logic        SYS_TIME_UPDATE,
  input  logic        DATA_WR,
  input  logic [63:0] TIME_START_z,
  input  logic [15:0] N_impuls_z,
  input  logic [31:0] Interval_Ti_z,
  input  logic [31:0] Interval_Tp_z,
  input  logic [31:0] Tblank1_z,
  input  logic [31:0] Tblank2_z,
  output logic        REQ_COMM,
  output logic        IMP,
  output logic        BLANK,
  output logic        BUSY,
  output logic        CMD_START,
  output logic        LATE,
  output logic        TOUT
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ARMED, S_PULSE, S_PAUSE} state_t;

  state_t      r_state;
  logic [63:0] r_ts;
  logic [15:0] r_n;
  logic [31:0] r_ti, r_tp, r_tb1, r_tb2;
  logic [31:0] r_hi_cnt, r_lo_cnt;
  logic [15:0] r_pcnt;
  logic [2:0]  r_stu;
  logic        r_req_comm, r_imp, r_blank, r_busy, r_cmd_start, r_late;

  logic        w_stu_rise, w_active, w_tmo;
  logic        w_late_new, w_blank_new, w_blank_arm, w_start;
  logic [31:0] w_ti_eff, w_lo_nxt;
  logic [15:0] w_pcnt_dec;
  logic        w_pblank_first, w_pblank_nxt;

  assign w_stu_rise  = r_stu[1] & ~r_stu[2];
  assign w_active    = r_state inside {S_ARMED, S_PULSE, S_PAUSE};
  assign w_late_new  = ({1'b0, TIME_START_z} + 65'(LATE_MARGIN)) < {1'b0, TIME};
  assign w_blank_new = ({1'b0, TIME} + {33'b0, Tblank1_z}) >= {1'b0, TIME_START_z};
  assign w_blank_arm = ({1'b0, TIME} + {33'b0, r_tb1}) >= {1'b0, r_ts};
  assign w_start     = TIME >= r_ts;
  assign w_ti_eff    = (r_ti == 32'd0) ? 32'd1 : r_ti;
  assign w_lo_nxt    = r_lo_cnt - 32'd1;
  assign w_pcnt_dec  = r_pcnt - 16'd1;
  // Pause blanking: lead-out window at the start, lead-in window at the end.
  assign w_pblank_first = (r_tb2 != 32'd0) || (r_tp <= r_tb1);
  assign w_pblank_nxt   = ((r_tp - w_lo_nxt) < r_tb2) || (w_lo_nxt <= r_tb1);

`ifdef SCHED_TIMEOUT_EN
  logic [31:0] r_wcnt;
  logic        r_tout;
  assign w_tmo = (r_state == S_WAIT) && !DATA_WR && (r_wcnt == TIMEOUT - 1);
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_wcnt <= '0;
      r_tout <= 1'b0;
    end else begin
      r_wcnt <= (r_state == S_WAIT) ? r_wcnt + 32'd1 : 32'd0;
      if (w_tmo) r_tout <= 1'b1;
    end
  end
  assign TOUT = r_tout;
`else
  assign w_tmo = 1'b0;
  // TIMEOUT has no effect without the watchdog.
  assign TOUT  = 1'b0 && (TIMEOUT != 0);
`endif

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ts        <= '0;
      r_n         <= '0;
      r_ti        <= '0;
      r_tp        <= '0;
      r_tb1       <= '0;
      r_tb2       <= '0;
      r_hi_cnt    <= '0;
      r_lo_cnt    <= '0;
      r_pcnt      <= '0;
      r_stu       <= '0;
      r_req_comm  <= 1'b0;
      r_imp       <= 1'b0;
      r_blank     <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_start <= 1'b0;
      r_late      <= 1'b0;
    end else begin
      r_stu       <= {r_stu[1:0], SYS_TIME_UPDATE};
      r_req_comm  <= 1'b0;
      r_cmd_start <= 1'b0;
      if (w_stu_rise && w_active) begin
        // Abort issues the request on the same edge so it lines up with IMP dropping.
        r_state    <= S_WAIT;
        r_req_comm <= 1'b1;
        r_imp      <= 1'b0;
        r_blank    <= 1'b0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_REQ;
          S_REQ: begin
            r_req_comm <= 1'b1;
            r_state    <= S_WAIT;
          end
          S_WAIT: begin
            if (DATA_WR) begin
              r_ts  <= TIME_START_z;
              r_n   <= N_impuls_z;
              r_ti  <= Interval_Ti_z;
              r_tp  <= Interval_Tp_z;
              r_tb1 <= Tblank1_z;
              r_tb2 <= Tblank2_z;
              if (w_late_new) begin
                r_late  <= 1'b1;
                r_state <= S_REQ;
              end else if (N_impuls_z == 16'd0) begin
                r_state <= S_REQ;
              end else begin
                r_state <= S_ARMED;
                r_busy  <= 1'b1;
                r_blank <= w_blank_new;
              end
            end else if (w_tmo) begin
              r_state <= S_REQ;
            end
          end
          S_ARMED: begin
            if (w_start) begin
              r_state     <= S_PULSE;
              r_imp       <= 1'b1;
              r_blank     <= 1'b1;
              r_cmd_start <= 1'b1;
              r_hi_cnt    <= w_ti_eff;
              r_pcnt      <= r_n;
            end else begin
              r_blank <= w_blank_arm;
            end
          end
          S_PULSE: begin
            if (r_hi_cnt <= 32'd1) begin
              r_pcnt <= w_pcnt_dec;
              if (r_tp != 32'd0) begin
                r_state  <= S_PAUSE;
                r_lo_cnt <= r_tp;
                r_imp    <= 1'b0;
                r_blank  <= w_pblank_first;
              end else if (w_pcnt_dec != 16'd0) begin
                r_hi_cnt <= w_ti_eff;
              end else begin
                r_state <= S_REQ;
                r_imp   <= 1'b0;
                r_blank <= 1'b0;
                r_busy  <= 1'b0;
              end
            end else begin
              r_hi_cnt <= r_hi_cnt - 32'd1;
            end
          end
          S_PAUSE: begin
            if (r_lo_cnt <= 32'd1) begin
              if (r_pcnt != 16'd0) begin
                r_state  <= S_PULSE;
                r_imp    <= 1'b1;
                r_blank  <= 1'b1;
                r_hi_cnt <= w_ti_eff;
              end else begin
                r_state <= S_REQ;
                r_blank <= 1'b0;
                r_busy  <= 1'b0;
              end
            end else begin
              r_lo_cnt <= w_lo_nxt;
              r_blank  <= w_pblank_nxt;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign REQ_COMM  = r_req_comm;
  assign IMP       = r_imp;
  assign BLANK     = r_blank;
  assign BUSY      = r_busy;
  assign CMD_START = r_cmd_start;
  assign LATE      = r_late;

endmodule

// File: tb/tb_cmd_exec_sched.sv
// Directed bench for cmd_exec_sched: train shape, late/empty commands, abort, stray strobe, watchdog.
module tb_cmd_exec_sched;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic [63:0] sys_time;
  logic        stu, data_wr;
  logic [63:0] ts;
  logic [15:0] n_imp;
  logic [31:0] ti, tp, tb1, tb2;
  logic        req_comm, imp, blank, busy, cmd_start, late, tout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] tr_time[$];
  logic        tr_imp[$];
  logic        tr_blank[$];
  logic        tr_cs[$];
  logic [63:0] rise_t[$];
  logic        got_req;
  logic [63:0] req_t, cs_t, blank_first;
  int          hi_cyc, cs_n;

  always #5 CLK = ~CLK;

  cmd_exec_sched #(.TIMEOUT(16), .LATE_MARGIN(0)) dut (
    .CLK(CLK), .rst_n(rst_n), .TIME(sys_time), .SYS_TIME_UPDATE(stu), .DATA_WR(data_wr),
    .TIME_START_z(ts), .N_impuls_z(n_imp), .Interval_Ti_z(ti), .Interval_Tp_z(tp),
    .Tblank1_z(tb1), .Tblank2_z(tb2), .REQ_COMM(req_comm), .IMP(imp), .BLANK(blank),
    .BUSY(busy), .CMD_START(cmd_start), .LATE(late), .TOUT(tout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    sys_time = sys_time + 64'd1;
  endtask

  task automatic send(input logic [63:0] now, input logic [63:0] t_start, input logic [15:0] n,
                      input logic [31:0] t_hi, input logic [31:0] t_lo,
                      input logic [31:0] b1, input logic [31:0] b2);
    sys_time = now;
    ts = t_start; n_imp = n; ti = t_hi; tp = t_lo; tb1 = b1; tb2 = b2;
    data_wr = 1'b1;
    step();
    data_wr = 1'b0;
  endtask

  // Records outputs each cycle until REQ_COMM, optionally raising SYS_TIME_UPDATE or a stray DATA_WR.
  task automatic run_trace(input int max_cyc, input int stu_idx, input int dwr_idx);
    tr_time.delete(); tr_imp.delete(); tr_blank.delete(); tr_cs.delete(); rise_t.delete();
    got_req = 1'b0; req_t = '0;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      data_wr = 1'b0;
      tr_time.push_back(sys_time);
      tr_imp.push_back(imp);
      tr_blank.push_back(blank);
      tr_cs.push_back(cmd_start);
      if (req_comm) begin
        got_req = 1'b1;
        req_t   = sys_time;
        break;
      end
      if (i == stu_idx) stu = 1'b1;
      if (i == dwr_idx) begin
        data_wr = 1'b1; ts = 64'd0; n_imp = 16'd7; ti = 32'd20; tp = 32'd9;
      end
    end
    hi_cyc = 0; cs_n = 0; cs_t = '0; blank_first = '1;
    for (int i = 0; i < tr_time.size(); i++) begin
      if (tr_imp[i]) hi_cyc++;
      if (tr_imp[i] && (i == 0 || !tr_imp[i-1])) rise_t.push_back(tr_time[i]);
      if (tr_cs[i]) begin cs_n++; cs_t = tr_time[i]; end
      if (tr_blank[i] && blank_first == '1) blank_first = tr_time[i];
    end
  endtask

  function automatic logic bit_at(input logic [63:0] t, input bit sel_blank);
    for (int i = 0; i < tr_time.size(); i++)
      if (tr_time[i] == t) return sel_blank ? tr_blank[i] : tr_imp[i];
    return 1'bx;
  endfunction

  function automatic logic [63:0] rise_at(input int n);
    return (n < rise_t.size()) ? rise_t[n] : '1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int cnt;
    rst_n = 1'b0; sys_time = '0; stu = 1'b0; data_wr = 1'b0;
    ts = '0; n_imp = '0; ti = '0; tp = '0; tb1 = '0; tb2 = '0;
    repeat (3) step();
    check("rst_outputs", {req_comm, imp, blank, busy, cmd_start, late, tout}, 0);
    rst_n = 1'b1;
    step();
    check("req_cycle1", req_comm, 0);
    step();
    check("req_cycle2", req_comm, 1);

    // Basic train: TS=1000, N=3, Ti=10, Tp=20, blanks 2/2
    send(64'd980, 64'd1000, 16'd3, 32'd10, 32'd20, 32'd2, 32'd2);
    check("basic_busy", busy, 1);
    check("basic_blank_early", blank, 0);
    run_trace(300, -1, -1);
    check("basic_req_seen", got_req, 1);
    check("basic_rises", rise_t.size(), 3);
    check("basic_rise0", rise_at(0), 1001);
    check("basic_rise1", rise_at(1), 1031);
    check("basic_rise2", rise_at(2), 1061);
    check("basic_hi_cycles", hi_cyc, 30);
    check("basic_cmd_start_n", cs_n, 1);
    check("basic_cmd_start_t", cs_t, 1001);
    check("basic_blank_first", blank_first, 999);
    check("basic_blank_tail1", bit_at(64'd1012, 1'b1), 1);
    check("basic_blank_gap", bit_at(64'd1013, 1'b1), 0);
    check("basic_blank_lead_off", bit_at(64'd1028, 1'b1), 0);
    check("basic_blank_lead_on", bit_at(64'd1029, 1'b1), 1);
    check("basic_req_time", req_t, 1092);

    // Late command
    send(64'd100, 64'd50, 16'd3, 32'd10, 32'd20, 32'd2, 32'd2);
    check("late_flag", late, 1);
    check("late_busy", busy, 0);
    check("late_req_not_yet", req_comm, 0);
    step();
    check("late_rereq", req_comm, 1);
    check("late_no_imp", imp, 0);

    // Empty command
    send(64'd200, 64'd500, 16'd0, 32'd10, 32'd20, 32'd2, 32'd2);
    check("n0_busy", busy, 0);
    check("n0_late_sticky", late, 1);
    step();
    check("n0_rereq", req_comm, 1);
    check("n0_no_imp", imp, 0);

    // Ti=0, Tp=0, N=2: two back-to-back single-cycle pulses
    send(64'd300, 64'd305, 16'd2, 32'd0, 32'd0, 32'd0, 32'd0);
    run_trace(60, -1, -1);
    check("degen_req_seen", got_req, 1);
    check("degen_rises", rise_t.size(), 1);
    check("degen_rise0", rise_at(0), 306);
    check("degen_hi_cycles", hi_cyc, 2);
    check("degen_req_time", req_t, 309);

    // Abort: SYS_TIME_UPDATE driven high in the cycle with TIME=409, mid first pulse
    send(64'd400, 64'd405, 16'd5, 32'd10, 32'd5, 32'd2, 32'd2);
    run_trace(100, 7, -1);
    stu = 1'b0;
    check("abort_req_seen", got_req, 1);
    check("abort_req_time", req_t, 412);
    check("abort_imp_before", bit_at(64'd411, 1'b0), 1);
    check("abort_imp_after", bit_at(64'd412, 1'b0), 0);
    check("abort_blank_after", bit_at(64'd412, 1'b1), 0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (imp) cnt++;
    end
    check("abort_no_more_pulses", cnt, 0);

    // Stray DATA_WR during the first pulse must not disturb the train
    send(64'd600, 64'd604, 16'd2, 32'd4, 32'd3, 32'd1, 32'd1);
    run_trace(100, -1, 4);
    check("stray_req_seen", got_req, 1);
    check("stray_rises", rise_t.size(), 2);
    check("stray_rise0", rise_at(0), 605);
    check("stray_rise1", rise_at(1), 612);
    check("stray_hi_cycles", hi_cyc, 8);
    check("stray_cmd_start_n", cs_n, 1);
    check("stray_req_time", req_t, 620);

    // No DATA_WR after the last request
    cnt = 0;
`ifdef SCHED_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      step();
      if (req_comm) cnt++;
    end
    check("tmo_quiet", cnt, 0);
    check("tmo_flag", tout, 1);
    step();
    check("tmo_rereq_17", req_comm, 1);
`else
    for (int i = 0; i < 10000; i++) begin
      step();
      if (req_comm) cnt++;
    end
    check("notmo_no_rereq", cnt, 0);
    check("notmo_tout", tout, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
